// File: rtl/sha256_job_arbiter.sv
// Round-robin job arbiter/sequencer in front of a shared sha256_processor.
// Optional stall timeout with ABORT state: define SHA_ARB_TIMEOUT_EN.
module sha256_job_arbiter #(
  parameter int N_REQ          = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 proc_rst,
  output logic                 proc_start,
  output logic [7:0]           proc_data,
  output logic                 proc_valid,
  output logic                 proc_last,
  input  logic                 proc_accept,
  input  logic                 proc_done,
  input  logic [255:0]         proc_hash,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic [255:0]         resp_hash,
  output logic                 resp_err,
  output logic                 busy
);

  localparam int unsigned NR = N_REQ;

  if (ID_W != $clog2(N_REQ) || N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("sha256_job_arbiter: illegal parameter combination");
  end

`ifdef SHA_ARB_TIMEOUT_EN
  typedef enum logic [2:0] {S_IDLE, S_PRST, S_START, S_STREAM, S_WAIT, S_RESP, S_ABORT} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_PRST, S_START, S_STREAM, S_WAIT, S_RESP} state_t;
`endif

  state_t          state, state_n;
  logic [ID_W-1:0] grant, last_grant, pick;
  logic            any_req;
  logic            xfer;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    int unsigned idx;
    idx     = '0;
    pick    = '0;
    any_req = 1'b0;
    for (int unsigned k = 1; k <= NR; k++) begin
      idx = 32'(last_grant) + k;
      if (idx >= NR) idx = idx - NR;
      if (!any_req && req_valid[idx[ID_W-1:0]]) begin
        any_req = 1'b1;
        pick    = idx[ID_W-1:0];
      end
    end
  end

  assign xfer = (state == S_STREAM) && req_valid[grant] && proc_accept;

`ifdef SHA_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] stall_cnt;
  logic          timed_out;

  assign timed_out = (stall_cnt == CW'(TIMEOUT_CYCLES));

  // Block-gap cycles (valid high, accept low) neither clear nor advance the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else begin
      case (state)
        S_STREAM: begin
          if (xfer)                   stall_cnt <= '0;
          else if (!req_valid[grant]) stall_cnt <= stall_cnt + 1'b1;
        end
        S_WAIT:   stall_cnt <= stall_cnt + 1'b1;
        default:  stall_cnt <= '0;
      endcase
    end
  end
`endif

  always_comb begin
    state_n    = state;
    req_ready  = '0;
    proc_start = 1'b0;
    proc_data  = '0;
    proc_valid = 1'b0;
    proc_last  = 1'b0;
    case (state)
      S_IDLE:  if (any_req) state_n = S_PRST;
      S_PRST:  state_n = S_START;
      S_START: begin
        proc_start = 1'b1;
        state_n    = S_STREAM;
      end
      S_STREAM: begin
        req_ready[grant] = proc_accept;
        proc_data        = req_data[{grant, 3'b000} +: 8];
        proc_valid       = req_valid[grant] & proc_accept;
        proc_last        = req_last[grant];
        if (xfer && req_last[grant]) state_n = S_WAIT;
`ifdef SHA_ARB_TIMEOUT_EN
        else if (timed_out)          state_n = S_ABORT;
`endif
      end
      S_WAIT: begin
        if (proc_done)      state_n = S_RESP;
`ifdef SHA_ARB_TIMEOUT_EN
        else if (timed_out) state_n = S_ABORT;
`endif
      end
      S_RESP:  if (resp_ready) state_n = S_IDLE;
`ifdef SHA_ARB_TIMEOUT_EN
      S_ABORT: state_n = S_RESP;
`endif
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      grant      <= '0;
      last_grant <= ID_W'(N_REQ - 1);
    end else begin
      state <= state_n;
      if (state == S_IDLE && any_req) begin
        grant      <= pick;
        last_grant <= pick;
      end
    end
  end

`ifdef SHA_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_hash <= '0;
      resp_id   <= '0;
      resp_err  <= 1'b0;
    end else if (state == S_WAIT && proc_done) begin
      resp_hash <= proc_hash;
      resp_id   <= grant;
      resp_err  <= 1'b0;
    end else if (state == S_ABORT) begin
      resp_hash <= '0;
      resp_id   <= grant;
      resp_err  <= 1'b1;
    end
  end

  assign proc_rst = ~rst_n | (state == S_PRST) | (state == S_ABORT);
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_hash <= '0;
      resp_id   <= '0;
    end else if (state == S_WAIT && proc_done) begin
      resp_hash <= proc_hash;
      resp_id   <= grant;
    end
  end

  assign resp_err = 1'b0;
  assign proc_rst = ~rst_n | (state == S_PRST);
`endif

  assign resp_valid = (state == S_RESP);
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_sha256_job_arbiter.sv
// Directed bench for sha256_job_arbiter with a behavioural processor stand-in
// whose digest is a byte count/sum/history signature (real digest for "abc").
module tb_sha256_job_arbiter;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
`ifdef SHA_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif
  localparam logic [255:0] ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic               proc_rst, proc_start, proc_valid, proc_last;
  logic [7:0]         proc_data;
  logic               proc_accept, proc_done;
  logic [255:0]       proc_hash;
  logic               resp_valid, resp_ready;
  logic [ID_W-1:0]    resp_id;
  logic [255:0]       resp_hash;
  logic               resp_err, busy;

  sha256_job_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .proc_rst(proc_rst),
    .proc_start(proc_start), .proc_data(proc_data), .proc_valid(proc_valid),
    .proc_last(proc_last), .proc_accept(proc_accept), .proc_done(proc_done),
    .proc_hash(proc_hash), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_hash(resp_hash), .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Processor stand-in: 64-byte blocks, 7-cycle compression gap, DONE until reset.
  typedef enum logic [1:0] {M_IDLE, M_LOAD, M_PROC, M_DONE} mstate_t;
  mstate_t      m_st;
  logic [5:0]   m_blk;
  logic [2:0]   m_pcnt;
  logic         m_lastseen;
  logic [31:0]  m_cnt, m_sum;
  logic [191:0] m_sh;

  always @(posedge clk) begin
    if (proc_rst) begin
      m_st <= M_IDLE; m_blk <= '0; m_pcnt <= '0; m_lastseen <= 1'b0;
      m_cnt <= '0; m_sum <= '0; m_sh <= '0;
    end else begin
      case (m_st)
        M_IDLE: if (proc_start) m_st <= M_LOAD;
        M_LOAD: if (proc_valid) begin
          m_cnt <= m_cnt + 1;
          m_sum <= m_sum + 32'(proc_data);
          m_sh  <= {m_sh[183:0], proc_data};
          m_blk <= (proc_last || m_blk == 6'd63) ? 6'd0 : m_blk + 6'd1;
          if (proc_last) begin
            m_lastseen <= 1'b1;
            m_st       <= M_PROC;
          end else if (m_blk == 6'd63) begin
            m_st <= M_PROC;
          end
        end
        M_PROC: if (m_pcnt == 3'd6) begin
          m_pcnt <= '0;
          m_st   <= m_lastseen ? M_DONE : M_LOAD;
        end else begin
          m_pcnt <= m_pcnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign proc_accept = (m_st == M_LOAD);
  assign proc_done   = (m_st == M_DONE);
  assign proc_hash   = (m_cnt == 32'd3 && m_sh[23:0] == 24'h616263) ? ABC : {m_cnt, m_sum, m_sh};

  // Requester-side job state, all driven from the single stimulus process.
  logic [7:0]   mem [N_REQ][128];
  int           len [N_REQ];
  int           ptr [N_REQ];
  int           stall_at [N_REQ];
  logic [255:0] expv [N_REQ];
  logic [N_REQ-1:0] active, stall, fire;
  logic         ack;
  int n_checks = 0, n_fail = 0;
  int cyc = 0, t_req = 0, first_xfer = -1, owner = -1;
  int rst_pulses = 0, start_pulses = 0, bad_ready = 0, gap_cnt = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] model(input int i);
    logic [31:0]  c, s;
    logic [191:0] h;
    c = '0; s = '0; h = '0;
    for (int k = 0; k < len[i]; k++) begin
      c = c + 1;
      s = s + 32'(mem[i][k]);
      h = {h[183:0], mem[i][k]};
    end
    if (c == 32'd3 && h[23:0] == 24'h616263) return ABC;
    return {c, s, h};
  endfunction

  task automatic drive();
    for (int i = 0; i < N_REQ; i++) begin
      if (active[i] && ptr[i] == stall_at[i]) stall[i] = 1'b1;
      req_valid[i]       = active[i] && !stall[i];
      req_data[8*i +: 8] = active[i] ? mem[i][ptr[i]] : 8'h00;
      req_last[i]        = active[i] && (ptr[i] == len[i] - 1);
    end
  endtask

  // One clock: apply last cycle's transfers at negedge, then sample the cycle.
  task automatic tick();
    @(negedge clk);
    resp_ready = ack;
    for (int i = 0; i < N_REQ; i++)
      if (fire[i]) begin
        ptr[i]++;
        if (ptr[i] >= len[i]) active[i] = 1'b0;
      end
    drive();
    #1;
    fire = req_valid & req_ready;
    if (rst_n && proc_rst) rst_pulses++;
    if (proc_start) start_pulses++;
    if ((req_ready & (req_ready - 1'b1)) != '0) bad_ready++;
    if (req_ready != '0 && !proc_accept) bad_ready++;
    for (int i = 0; i < N_REQ; i++) begin
      if (fire[i]) owner = i;
      if (req_ready[i] && owner >= 0 && owner != i) bad_ready++;
    end
    if (owner >= 0 && req_valid[owner] && !req_ready[owner]) gap_cnt++;
    if (fire != '0 && first_xfer < 0) first_xfer = cyc;
    if (resp_valid && resp_ready) owner = -1;
    cyc++;
  endtask

  task automatic clear_jobs();
    active = '0; stall = '0; fire = '0; owner = -1;
    for (int i = 0; i < N_REQ; i++) begin
      ptr[i] = 0; len[i] = 0; stall_at[i] = -1;
    end
    drive();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_jobs();
    tick(); tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic load_abc(input int i);
    mem[i][0] = 8'h61; mem[i][1] = 8'h62; mem[i][2] = 8'h63;
  endtask

  task automatic load_pat(input int i, input int n, input int seed);
    for (int k = 0; k < n; k++) mem[i][k] = 8'(seed + 7 * k);
  endtask

  task automatic start_job(input int i, input int n);
    len[i] = n; ptr[i] = 0; stall[i] = 1'b0; stall_at[i] = -1;
    active[i] = 1'b1;
    expv[i] = model(i);
    t_req = cyc; first_xfer = -1;
  endtask

  task automatic wait_resp(input int hold, output logic [ID_W-1:0] id,
                           output logic [255:0] hash, output logic err,
                           output int unstable, output int early3);
    int n;
    n = 0; unstable = 0; early3 = 0;
    id = '0; hash = '0; err = 1'b0;
    do begin
      tick();
      n++;
    end while (!resp_valid && n < 3000);
    if (!resp_valid) begin
      check("resp_wait_expired", 256'(resp_valid), 256'd1);
    end else begin
      id = resp_id; hash = resp_hash; err = resp_err;
      for (int h = 0; h < hold; h++) begin
        tick();
        if (!resp_valid || resp_id !== id || resp_hash !== hash || resp_err !== err) unstable++;
        if (req_ready[3]) early3++;
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
    end
  endtask

  logic [ID_W-1:0] rid;
  logic [255:0]    rh;
  logic            rerr;
  int              uns, e3;

  initial begin
    rst_n = 1'b0; ack = 1'b0; resp_ready = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    clear_jobs();
    tick(); tick();
    check("rst_proc_rst", 256'(proc_rst), 256'd1);
    check("rst_outputs", 256'({resp_valid, busy, proc_start, proc_valid, proc_last, resp_err, req_ready, proc_data, resp_id}), 256'd0);
    check("rst_resp_hash", resp_hash, 256'd0);
    rst_n = 1'b1;
    tick();

    // Single requester "abc"
    rst_pulses = 0; start_pulses = 0; bad_ready = 0;
    load_abc(0);
    start_job(0, 3);
    wait_resp(0, rid, rh, rerr, uns, e3);
    check("abc_id", 256'(rid), 256'd0);
    check("abc_hash", rh, ABC);
    check("abc_err", 256'(rerr), 256'd0);
    check("abc_first_xfer_cycle", 256'(first_xfer - t_req), 256'd3);
    check("abc_proc_rst_pulses", 256'(rst_pulses), 256'd1);
    check("abc_proc_start_pulses", 256'(start_pulses), 256'd1);

    // Simultaneous 1 and 2 after reset, then 0,1,2 together
    do_reset();
    bad_ready = 0;
    load_pat(1, 5, 8'h10); load_pat(2, 6, 8'h20);
    start_job(1, 5); start_job(2, 6);
    wait_resp(0, rid, rh, rerr, uns, e3);
    check("rr1_id", 256'(rid), 256'd1);
    check("rr1_hash", rh, expv[1]);
    wait_resp(0, rid, rh, rerr, uns, e3);
    check("rr2_id", 256'(rid), 256'd2);
    check("rr2_hash", rh, expv[2]);
    load_pat(0, 4, 8'h30); load_pat(1, 9, 8'h40); load_pat(2, 2, 8'h50);
    start_job(0, 4); start_job(1, 9); start_job(2, 2);
    for (int j = 0; j < 3; j++) begin
      wait_resp(0, rid, rh, rerr, uns, e3);
      check($sformatf("rr_round2_id%0d", j), 256'(rid), 256'(j));
      check($sformatf("rr_round2_hash%0d", j), rh, expv[j]);
    end
    check("rr_ready_exclusive", 256'(bad_ready), 256'd0);

    // Block boundaries: 64-byte then 100-byte message
    bad_ready = 0; gap_cnt = 0;
    load_pat(1, 64, 8'h03);
    start_job(1, 64);
    wait_resp(0, rid, rh, rerr, uns, e3);
    check("blk64_hash", rh, expv[1]);
    check("blk64_gap", 256'(gap_cnt), 256'd0);
    gap_cnt = 0;
    load_pat(2, 100, 8'h81);
    start_job(2, 100);
    wait_resp(0, rid, rh, rerr, uns, e3);
    check("blk100_id", 256'(rid), 256'd2);
    check("blk100_hash", rh, expv[2]);
    check("blk100_gap_cycles", 256'(gap_cnt), 256'd7);
    check("blk_ready_gated", 256'(bad_ready), 256'd0);

    // Response backpressure with requester 3 pending
    load_abc(0);
    start_job(0, 3);
    for (int n = 0; n < 20 && owner != 0; n++) tick();
    load_pat(3, 8, 8'hc5);
    start_job(3, 8);
    wait_resp(50, rid, rh, rerr, uns, e3);
    check("bp_id", 256'(rid), 256'd0);
    check("bp_hash", rh, ABC);
    check("bp_stable", 256'(uns), 256'd0);
    check("bp_no_grant3", 256'(e3), 256'd0);
    wait_resp(0, rid, rh, rerr, uns, e3);
    check("bp_next_id", 256'(rid), 256'd3);
    check("bp_next_hash", rh, expv[3]);

    // Reset after 10 bytes of a job
    load_pat(2, 20, 8'h11);
    start_job(2, 20);
    for (int n = 0; n < 200 && ptr[2] < 10; n++) tick();
    check("mid_reached_10", 256'(ptr[2]), 256'd10);
    rst_n = 1'b0;
    #1;
    check("mid_resp_valid", 256'(resp_valid), 256'd0);
    check("mid_proc_rst", 256'(proc_rst), 256'd1);
    check("mid_busy", 256'(busy), 256'd0);
    check("mid_req_ready", 256'(req_ready), 256'd0);
    clear_jobs();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    load_abc(0);
    start_job(0, 3);
    wait_resp(0, rid, rh, rerr, uns, e3);
    check("post_rst_id", 256'(rid), 256'd0);
    check("post_rst_hash", rh, ABC);

`ifdef SHA_ARB_TIMEOUT_EN
    // Requester 0 stalls after 5 bytes
    load_pat(0, 20, 8'h44);
    start_job(0, 20);
    stall_at[0] = 5;
    wait_resp(0, rid, rh, rerr, uns, e3);
    check("to_err", 256'(rerr), 256'd1);
    check("to_hash", rh, 256'd0);
    check("to_id", 256'(rid), 256'd0);
    active[0] = 1'b0;
    load_abc(1);
    start_job(1, 3);
    wait_resp(0, rid, rh, rerr, uns, e3);
    check("to_next_id", 256'(rid), 256'd1);
    check("to_next_hash", rh, ABC);
    check("to_next_err", 256'(rerr), 256'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_job_arbiter.md
# sha256_job_arbiter

Round-robin job arbiter and sequencer placed in front of the shared `sha256_processor`. It accepts byte-stream hash jobs from `N_REQ` requesters and grants the processor to one requester per message. For each job it clears the processor with a reset pulse, issues `start`, and forwards the granted byte stream under processor flow control. It then captures the 256-bit digest and returns it on a response channel tagged with the requester ID.

## Interface
- `N_REQ`, default 4: number of requesters, range 2..8.
- `ID_W`, default 2: response ID width, equal to `$clog2(N_REQ)`.
- `TIMEOUT_CYCLES`, default 1024: stall limit. Used only with `SHA_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock; everything is `posedge`.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: per-requester byte valid. A rising `req_valid` also acts as the job request.
- `req_data` in 8*N_REQ: bytes; requester i occupies `[8i+7:8i]`.
- `req_last` in N_REQ: marks the final byte of a message.
- `req_ready` out N_REQ: byte accepted when `req_valid[i] & req_ready[i]`.
- `proc_rst` out 1: active-high reset to the processor.
- `proc_start` out 1: processor start pulse.
- `proc_data` out 8: processor data.
- `proc_valid` out 1: processor data valid.
- `proc_last` out 1: processor data last.
- `proc_accept` in 1: processor is in its LOAD state (exported state decode).
- `proc_done` in 1: processor done.
- `proc_hash` in 256: processor digest.
- `resp_valid` out 1: response valid.
- `resp_ready` in 1: response ready.
- `resp_id` out ID_W: ID of the requester that owns the response.
- `resp_hash` out 256: registered digest.
- `resp_err` out 1: job aborted. Tied 0 without the macro.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE → PRST → START → STREAM → WAIT → RESP → IDLE. The ABORT state exists only with the macro.
- **IDLE**
  - If any `req_valid` is high, register `grant` = first requester with `req_valid` high, searching from `(last_grant+1) mod N_REQ` upward.
  - Set `last_grant <= grant` and go to PRST.
  - Reset value of `last_grant` is N_REQ-1, so requester 0 has highest priority after reset.
- **PRST:** `proc_rst`=1 for exactly one cycle, which clears the processor out of DONE. Go to START.
- **START:** `proc_start`=1 for exactly one cycle. Go to STREAM.
- **STREAM**
  - `req_ready[grant] = proc_accept`. All other `req_ready` bits are 0.
  - `proc_data = req_data[grant]`, `proc_valid = req_valid[grant] & proc_accept`, `proc_last = req_last[grant]`. These are combinational pass-through.
  - A transfer with `req_last` high moves to WAIT.
  - If `req_valid[grant]` deasserts, the grant is held and no transfer occurs.
- **WAIT:** when `proc_done` is high, set `resp_hash <= proc_hash`, `resp_id <= grant`, `resp_err <= 0`. Go to RESP.
- **RESP:** `resp_valid`=1. `resp_hash`, `resp_id` and `resp_err` are held stable until `resp_ready`; the handshake returns to IDLE. No new grant is made while in RESP.
- `proc_valid` and `proc_start` are 0 outside STREAM and START respectively.
- Messages must contain at least one byte; a zero-length job is not supported.

## Timing
- **Reset values:**
  - `proc_rst`=1 (`proc_rst = (state==PRST) | ~rst_n`).
  - All other outputs are 0. `resp_hash` is 0.
  - State is IDLE and `last_grant` is N_REQ-1.
- **Latency:** request seen in IDLE at cycle 0; PRST at cycle 1; START at cycle 2; STREAM at cycle 3. The first byte can transfer in cycle 3, since the processor enters LOAD on the edge that ends cycle 2.
- **Block boundaries:** after the 64th byte of a block, `proc_accept` drops and `req_ready` is 0 until the processor returns to LOAD. Bytes presented during that gap are not consumed.
- `resp_valid` rises one cycle after the first cycle `proc_done` is sampled high.
- The cycle after the RESP handshake is IDLE, and arbitration happens in that same IDLE cycle.
- **Reset mid-operation:** returns to IDLE immediately. `proc_rst` is high while `rst_n` is low. Any in-flight job is discarded with no response.

## Configuration
- **`SHA_ARB_TIMEOUT_EN` defined:**
  - A stall counter runs in STREAM. It clears on every transfer and increments each cycle `req_valid[grant]` is 0.
  - When it reaches `TIMEOUT_CYCLES`, the FSM enters ABORT.
  - ABORT lasts one cycle with `proc_rst`=1, then goes to RESP with `resp_err`=1, `resp_hash`=0, `resp_id`=grant.
  - The counter also runs in WAIT; a timeout there aborts the same way.
- **`SHA_ARB_TIMEOUT_EN` undefined:** no counter and no ABORT state. `resp_err` is constant 0 and the arbiter waits indefinitely.

## Test plan
- **Single requester:** requester 0 sends "abc" (0x61, 0x62, 0x63 with last) → `resp_id`=0, `resp_hash`=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, `resp_err`=0. Check first transfer in cycle 3 and one `proc_rst` and one `proc_start` pulse.
- **Simultaneous requests:** requesters 1 and 2 request in the same cycle after reset → requester 1 is served, then 2. A second round with 0, 1, 2 all requesting → order 0, 1, 2 after `last_grant`=2. No `req_ready` to non-granted requesters at any time.
- **Block boundary:** a 64-byte and a 100-byte message → `req_ready` is low from the 65th byte until the processor returns to LOAD. Digests match the C model; no byte is dropped or duplicated.
- **Response backpressure:** `resp_ready` held low for 50 cycles with requester 3 pending → `resp_hash` and `resp_id` stay stable and requester 3 is not granted until after the handshake.
- **Reset mid-stream:** `rst_n` asserted after 10 bytes of a job → `resp_valid`=0, `proc_rst`=1, state IDLE. After release, a fresh "abc" job produces the correct digest.
- **Timeout (macro on, `TIMEOUT_CYCLES`=16):** requester 0 stalls after 5 bytes → ABORT, then `resp_valid`=1 with `resp_err`=1 and `resp_hash`=0. The next job from requester 1 produces the correct digest.
